// File: rtl/filter_decimator.sv
`default_nettype none
// filter_decimator: block averager emitting one rounded mean per 2^AVG_LOG2 accepted samples.
// Rev 1.0
module filter_decimator #(
  parameter int REG_MAX  = 32,
  parameter int AVG_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [REG_MAX-1:0]  sample_in,
  input  logic                sample_valid,
  output logic [REG_MAX-1:0]  avg_out,
  output logic                avg_valid,
  output logic [AVG_LOG2-1:0] sample_cnt,
  output logic                busy
);

  localparam int ACC_W = REG_MAX + AVG_LOG2;
  localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(2 ** (AVG_LOG2 - 1));
  localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;

  typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} state_t;
  state_t state, state_nxt;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] sum_rnd;
  logic                    accept;
  logic                    last;
  logic [REG_MAX-1:0]      avg_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = ACCUM;
      ACCUM:   if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The guard bits in acc keep N full-scale samples plus the rounding offset in range.
  always_comb begin
    accept  = (state == ACCUM) && sample_valid;
    last    = accept && (sample_cnt == CNT_LAST);
    sum     = acc + {{AVG_LOG2{sample_in[REG_MAX-1]}}, sample_in};
    sum_rnd = sum + ROUND;
    avg_nxt = REG_MAX'(sum_rnd >>> AVG_LOG2);
  end

  assign busy = (state == ACCUM);

  // A completing sample wins over a falling enable so the final window is still reported.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      sample_cnt <= '0;
      avg_out    <= '0;
      avg_valid  <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (last) begin
        acc        <= '0;
        sample_cnt <= '0;
        avg_out    <= avg_nxt;
        avg_valid  <= 1'b1;
      end else if (accept && enable) begin
        acc        <= sum;
        sample_cnt <= sample_cnt + AVG_LOG2'(1);
      end else if (state != ACCUM || !enable) begin
        acc        <= '0;
        sample_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire
